// File: rtl/cbfp_denorm.sv
// cbfp_denorm: restores full scale to CBFP-normalized 16-lane complex blocks.
//
// Per-block real/imag exponents are queued in a small FIFO as the normalizer
// emits them; each arriving normalized block pops one pair and every lane is
// shifted by (BIAS - exp), with saturation on left shifts. Fixed 2-cycle
// pipeline: stage 1 captures lanes and shift amounts, stage 2 shifts and
// saturates into the output registers.
//
// Ports:
//   clk, rstn          clock; asynchronous active-high reset (rstn = 1 resets)
//   exp_valid/exp_ready exponent push handshake (exp_ready = FIFO not full)
//   exp_re, exp_im     per-block exponents, EXP_WIDTH bits each
//   din_valid          normalized block present this cycle
//   din_real/din_imag  16 signed lanes of IN_WIDTH bits
//   valid_out          denormalized block valid
//   dout_real/dout_imag 16 signed lanes of OUT_WIDTH bits, held when not valid
//   exp_count          FIFO occupancy
//   err_underflow      sticky: a block arrived with the FIFO empty
module cbfp_denorm #(
    parameter int IN_WIDTH   = 13,
    parameter int OUT_WIDTH  = 23,
    parameter int EXP_WIDTH  = 5,
    parameter int BIAS       = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                exp_valid,
    input  logic [EXP_WIDTH-1:0]                exp_re,
    input  logic [EXP_WIDTH-1:0]                exp_im,
    output logic                                exp_ready,
    input  logic                                din_valid,
    input  logic [15:0][IN_WIDTH-1:0]           din_real,
    input  logic [15:0][IN_WIDTH-1:0]           din_imag,
    output logic                                valid_out,
    output logic [15:0][OUT_WIDTH-1:0]          dout_real,
    output logic [15:0][OUT_WIDTH-1:0]          dout_imag,
    output logic [$clog2(FIFO_DEPTH):0]         exp_count,
    output logic                                err_underflow
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int SW   = EXP_WIDTH + 2;
    localparam int WW_A = OUT_WIDTH + EXP_WIDTH;
    localparam int WW_B = IN_WIDTH + BIAS + 1;
    // Working width must hold the largest left shift without wrapping.
    localparam int WW   = (WW_A > WW_B) ? WW_A : WW_B;

    localparam logic signed [WW-1:0] SAT_MAX =
        {{(WW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_MIN =
        {{(WW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // ---------------- exponent FIFO ----------------
    logic [EXP_WIDTH-1:0] fifo_re [FIFO_DEPTH];
    logic [EXP_WIDTH-1:0] fifo_im [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 push, pop, fifo_empty;
    logic [EXP_WIDTH-1:0] pop_re, pop_im;

    assign fifo_empty = (count == '0);
    assign exp_ready  = (count < CW'(FIFO_DEPTH));
    assign exp_count  = count;
    assign push       = exp_valid && exp_ready;
    assign pop        = din_valid && !fifo_empty;

    // An empty FIFO substitutes unity gain so the block still passes through.
    always_comb begin
        pop_re = EXP_WIDTH'(BIAS);
        pop_im = EXP_WIDTH'(BIAS);
        if (!fifo_empty) begin
            pop_re = fifo_re[rd_ptr];
            pop_im = fifo_im[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_re[wr_ptr] <= exp_re;
            fifo_im[wr_ptr] <= exp_im;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (din_valid && fifo_empty) err_underflow <= 1'b1;
        end
    end

    // ---------------- stage 1: capture lanes and shift amounts ----------------
    logic                        v1;
    logic [15:0][IN_WIDTH-1:0]   re1, im1;
    logic signed [SW-1:0]        sh_re1, sh_im1;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            v1     <= 1'b0;
            re1    <= '0;
            im1    <= '0;
            sh_re1 <= '0;
            sh_im1 <= '0;
        end else begin
            v1 <= din_valid;
            if (din_valid) begin
                re1    <= din_real;
                im1    <= din_imag;
                sh_re1 <= SW'(BIAS) - {2'b00, pop_re};
                sh_im1 <= SW'(BIAS) - {2'b00, pop_im};
            end
        end
    end

    // ---------------- stage 2: shift, saturate, register ----------------
    function automatic logic [OUT_WIDTH-1:0] scale(input logic [IN_WIDTH-1:0] x,
                                                   input logic signed [SW-1:0] s);
        logic signed [WW-1:0] ext;
        logic signed [WW-1:0] res;
        logic [SW-1:0]        mag;
        ext = WW'($signed(x));
        mag = s[SW-1] ? SW'(-s) : SW'(s);
        if (s[SW-1]) res = ext >>> mag;
        else         res = ext <<< mag;
        if (res > SAT_MAX)      scale = SAT_MAX[OUT_WIDTH-1:0];
        else if (res < SAT_MIN) scale = SAT_MIN[OUT_WIDTH-1:0];
        else                    scale = res[OUT_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            valid_out <= 1'b0;
            dout_real <= '0;
            dout_imag <= '0;
        end else begin
            valid_out <= v1;
            if (v1) begin
                for (int unsigned i = 0; i < 16; i++) begin
                    dout_real[i] <= scale(re1[i], sh_re1);
                    dout_imag[i] <= scale(im1[i], sh_im1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cbfp_denorm.sv
// Self-checking bench for cbfp_denorm: a default build and an OUT_WIDTH=20
// build share all inputs; expected outputs come from an arithmetic model
// (exponent queue, multiply/floor-divide, clamp).
module tb_cbfp_denorm;

    localparam int IN_W   = 13;
    localparam int OUT_W  = 23;
    localparam int OUT_W2 = 20;
    localparam int EXP_W  = 5;
    localparam int BIAS   = 10;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rstn;
    logic                       exp_valid, din_valid;
    logic [EXP_W-1:0]           exp_re, exp_im;
    logic [15:0][IN_W-1:0]      din_real, din_imag;
    logic                       exp_ready, valid_out, err_underflow;
    logic [15:0][OUT_W-1:0]     dout_real, dout_imag;
    logic [2:0]                 exp_count;
    logic                       exp_ready2, valid_out2, err_underflow2;
    logic [15:0][OUT_W2-1:0]    dout_real2, dout_imag2;
    logic [2:0]                 exp_count2;

    cbfp_denorm #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .EXP_WIDTH(EXP_W),
                  .BIAS(BIAS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .exp_valid(exp_valid), .exp_re(exp_re),
        .exp_im(exp_im), .exp_ready(exp_ready), .din_valid(din_valid),
        .din_real(din_real), .din_imag(din_imag), .valid_out(valid_out),
        .dout_real(dout_real), .dout_imag(dout_imag), .exp_count(exp_count),
        .err_underflow(err_underflow));

    cbfp_denorm #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W2), .EXP_WIDTH(EXP_W),
                  .BIAS(BIAS), .FIFO_DEPTH(DEPTH)) dut20 (
        .clk(clk), .rstn(rstn), .exp_valid(exp_valid), .exp_re(exp_re),
        .exp_im(exp_im), .exp_ready(exp_ready2), .din_valid(din_valid),
        .din_real(din_real), .din_imag(din_imag), .valid_out(valid_out2),
        .dout_real(dout_real2), .dout_imag(dout_imag2), .exp_count(exp_count2),
        .err_underflow(err_underflow2));

    int n_checks = 0;
    int n_errors = 0;

    // stimulus lanes for the next drive() call
    int stim_re[16];
    int stim_im[16];

    // reference model state
    int     q_re[$];
    int     q_im[$];
    bit     m_err;
    bit     s1_v;
    int     s1_x_re[16], s1_x_im[16];
    int     s1_e_re, s1_e_im;
    bit     m_vout;
    longint m_re[16], m_im[16], m_re2[16], m_im2[16];

    function automatic longint ref_denorm(longint x, int e, int ow);
        longint v, d, hi, lo;
        int s;
        s = BIAS - e;
        if (s >= 0) begin
            v = x * (longint'(1) << s);
        end else begin
            d = longint'(1) << (-s);
            if (x >= 0) v = x / d;
            else        v = -((-x + d - 1) / d);
        end
        hi = (longint'(1) << (ow - 1)) - 1;
        lo = -(longint'(1) << (ow - 1));
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

    function automatic int rnd_in();
        return int'($urandom_range(0, 8191)) - 4096;
    endfunction

    task automatic model_reset();
        q_re.delete();
        q_im.delete();
        m_err  = 0;
        s1_v   = 0;
        m_vout = 0;
        for (int i = 0; i < 16; i++) begin
            m_re[i] = 0; m_im[i] = 0; m_re2[i] = 0; m_im2[i] = 0;
        end
    endtask

    task automatic randomize_stim();
        for (int i = 0; i < 16; i++) begin
            stim_re[i] = rnd_in();
            stim_im[i] = rnd_in();
        end
    endtask

    // Present inputs for one clock, advance the model over that edge, then
    // return #1 after the edge with the inputs deasserted.
    task automatic drive(input bit ev, input int er, input int ei, input bit dv);
        int n;
        exp_valid = ev;
        exp_re    = EXP_W'(er);
        exp_im    = EXP_W'(ei);
        din_valid = dv;
        for (int i = 0; i < 16; i++) begin
            din_real[i] = IN_W'(stim_re[i]);
            din_imag[i] = IN_W'(stim_im[i]);
        end
        @(posedge clk);
        n = q_re.size();
        m_vout = s1_v;
        if (s1_v) begin
            for (int i = 0; i < 16; i++) begin
                m_re[i]  = ref_denorm(s1_x_re[i], s1_e_re, OUT_W);
                m_im[i]  = ref_denorm(s1_x_im[i], s1_e_im, OUT_W);
                m_re2[i] = ref_denorm(s1_x_re[i], s1_e_re, OUT_W2);
                m_im2[i] = ref_denorm(s1_x_im[i], s1_e_im, OUT_W2);
            end
        end
        s1_v = dv;
        if (dv) begin
            if (n > 0) begin
                s1_e_re = q_re.pop_front();
                s1_e_im = q_im.pop_front();
            end else begin
                s1_e_re = BIAS;
                s1_e_im = BIAS;
                m_err   = 1;
            end
            for (int i = 0; i < 16; i++) begin
                s1_x_re[i] = stim_re[i];
                s1_x_im[i] = stim_im[i];
            end
        end
        if (ev && n < DEPTH) begin
            q_re.push_back(er);
            q_im.push_back(ei);
        end
        #1;
        exp_valid = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        exp_valid = 0; din_valid = 0; exp_re = '0; exp_im = '0;
        din_real = '0; din_imag = '0;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (valid_out !== 1'b0 || valid_out2 !== 1'b0) begin
            n_errors++; $display("FAIL reset_valid: got %b/%b expected 0", valid_out, valid_out2);
        end
        n_checks++;
        if (exp_ready !== 1'b1 || exp_count !== 3'd0) begin
            n_errors++; $display("FAIL reset_fifo: got ready=%b count=%0d expected 1/0", exp_ready, exp_count);
        end
        n_checks++;
        if (err_underflow !== 1'b0) begin
            n_errors++; $display("FAIL reset_err: got %b expected 0", err_underflow);
        end
        n_checks++;
        if (dout_real !== '0 || dout_imag !== '0) begin
            n_errors++; $display("FAIL reset_dout: got nonzero lanes expected all 0");
        end
        rstn = 1'b0;
        model_reset();
    endtask

    task automatic test_unity();
        randomize_stim();
        stim_re[0] = 100;
        stim_im[0] = -7;
        drive(1, 10, 10, 0);
        drive(0, 0, 0, 1);
        n_checks++;
        if (valid_out !== 1'b0 || exp_count !== 3'd0) begin
            n_errors++; $display("FAIL unity_stage1: got valid=%b count=%0d expected 0/0", valid_out, exp_count);
        end
        drive(0, 0, 0, 0);
        n_checks++;
        if (valid_out !== 1'b1 || longint'($signed(dout_real[0])) != 100
            || longint'($signed(dout_imag[0])) != -7) begin
            n_errors++;
            $display("FAIL unity_lane0: got valid=%b re=%0d im=%0d expected 1/100/-7",
                     valid_out, $signed(dout_real[0]), $signed(dout_imag[0]));
        end
        for (int i = 1; i < 16; i++) begin
            n_checks++;
            if (longint'($signed(dout_real[i])) != longint'(stim_re[i])
                || longint'($signed(dout_imag[i])) != longint'(stim_im[i])) begin
                n_errors++;
                $display("FAIL unity_lane %0d: got %0d/%0d expected %0d/%0d", i,
                         $signed(dout_real[i]), $signed(dout_imag[i]), stim_re[i], stim_im[i]);
            end
        end
    endtask

    task automatic test_left_shift();
        longint want_re;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 16; i++) begin
                stim_re[i] = (pass == 0) ? 4095 : -4096;
                stim_im[i] = 100;
            end
            want_re = (pass == 0) ? 64'sd4193280 : -64'sd4194304;
            drive(1, 0, 3, 0);
            drive(0, 0, 0, 1);
            drive(0, 0, 0, 0);
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (valid_out !== 1'b1 || longint'($signed(dout_real[i])) != want_re
                    || longint'($signed(dout_imag[i])) != 12800) begin
                    n_errors++;
                    $display("FAIL left_shift pass %0d lane %0d: got %0d/%0d expected %0d/12800",
                             pass, i, $signed(dout_real[i]), $signed(dout_imag[i]), want_re);
                end
            end
        end
        // saturation in the narrow build, exact fit in the wide one
        randomize_stim();
        stim_re[0] = 4095;
        stim_im[0] = -4096;
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        n_checks++;
        if (valid_out2 !== 1'b1 || longint'($signed(dout_real2[0])) != 524287
            || longint'($signed(dout_imag2[0])) != -524288) begin
            n_errors++;
            $display("FAIL saturate20: got %0d/%0d expected 524287/-524288",
                     $signed(dout_real2[0]), $signed(dout_imag2[0]));
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (longint'($signed(dout_real[i])) != m_re[i] || longint'($signed(dout_imag[i])) != m_im[i]
                || longint'($signed(dout_real2[i])) != m_re2[i]
                || longint'($signed(dout_imag2[i])) != m_im2[i]) begin
                n_errors++;
                $display("FAIL saturate_lane %0d: got %0d/%0d %0d/%0d expected %0d/%0d %0d/%0d", i,
                         $signed(dout_real[i]), $signed(dout_imag[i]), $signed(dout_real2[i]),
                         $signed(dout_imag2[i]), m_re[i], m_im[i], m_re2[i], m_im2[i]);
            end
        end
    endtask

    task automatic test_right_shift();
        randomize_stim();
        stim_re[0] = -100;
        stim_im[0] = 100;
        drive(1, 15, 15, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        n_checks++;
        if (valid_out !== 1'b1 || longint'($signed(dout_real[0])) != -4
            || longint'($signed(dout_imag[0])) != 3) begin
            n_errors++;
            $display("FAIL right_shift: got %0d/%0d expected -4/3",
                     $signed(dout_real[0]), $signed(dout_imag[0]));
        end
        for (int i = 1; i < 16; i++) begin
            n_checks++;
            if (longint'($signed(dout_real[i])) != m_re[i] || longint'($signed(dout_imag[i])) != m_im[i]) begin
                n_errors++;
                $display("FAIL right_shift_lane %0d: got %0d/%0d expected %0d/%0d", i,
                         $signed(dout_real[i]), $signed(dout_imag[i]), m_re[i], m_im[i]);
            end
        end
    endtask

    task automatic test_fifo_full();
        bit want_v[6] = '{0, 1, 1, 1, 1, 0};
        for (int k = 0; k < 4; k++)
            drive(1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0);
        n_checks++;
        if (exp_count !== 3'd4 || exp_ready !== 1'b0) begin
            n_errors++; $display("FAIL fifo_full: got count=%0d ready=%b expected 4/0", exp_count, exp_ready);
        end
        drive(1, 0, 0, 0);
        n_checks++;
        if (exp_count !== 3'd4 || q_re.size() != 4) begin
            n_errors++; $display("FAIL fifo_overpush: got count=%0d expected 4", exp_count);
        end
        for (int k = 0; k < 6; k++) begin
            randomize_stim();
            drive(0, 0, 0, (k < 4));
            n_checks++;
            if (valid_out !== want_v[k]) begin
                n_errors++; $display("FAIL fifo_valid cycle %0d: got %b expected %b", k, valid_out, want_v[k]);
            end
            if (want_v[k]) begin
                for (int i = 0; i < 16; i++) begin
                    n_checks++;
                    if (longint'($signed(dout_real[i])) != m_re[i]
                        || longint'($signed(dout_imag[i])) != m_im[i]) begin
                        n_errors++;
                        $display("FAIL fifo_order cycle %0d lane %0d: got %0d/%0d expected %0d/%0d", k, i,
                                 $signed(dout_real[i]), $signed(dout_imag[i]), m_re[i], m_im[i]);
                    end
                end
            end
        end
        n_checks++;
        if (exp_count !== 3'd0 || exp_ready !== 1'b1) begin
            n_errors++; $display("FAIL fifo_drained: got count=%0d ready=%b expected 0/1", exp_count, exp_ready);
        end
    endtask

    task automatic test_underflow();
        randomize_stim();
        stim_re[0] = 55;
        drive(0, 0, 0, 1);
        n_checks++;
        if (err_underflow !== 1'b1 || exp_count !== 3'd0) begin
            n_errors++; $display("FAIL underflow_flag: got err=%b count=%0d expected 1/0", err_underflow, exp_count);
        end
        drive(0, 0, 0, 0);
        n_checks++;
        if (valid_out !== 1'b1 || longint'($signed(dout_real[0])) != 55) begin
            n_errors++; $display("FAIL underflow_data: got valid=%b re=%0d expected 1/55", valid_out, $signed(dout_real[0]));
        end
        repeat (3) drive(0, 0, 0, 0);
        n_checks++;
        if (err_underflow !== 1'b1 || valid_out !== 1'b0) begin
            n_errors++; $display("FAIL underflow_sticky: got err=%b valid=%b expected 1/0", err_underflow, valid_out);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (longint'($signed(dout_real[i])) != m_re[i] || longint'($signed(dout_imag[i])) != m_im[i]) begin
                n_errors++;
                $display("FAIL hold_lane %0d: got %0d/%0d expected %0d/%0d", i,
                         $signed(dout_real[i]), $signed(dout_imag[i]), m_re[i], m_im[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ev, dv;
        for (int c = 0; c < 60; c++) begin
            randomize_stim();
            ev = ($urandom_range(0, 2) != 0);
            dv = ($urandom_range(0, 1) != 0);
            drive(ev, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), dv);
            n_checks++;
            if (valid_out !== m_vout || exp_count !== 3'(q_re.size())
                || exp_ready !== (q_re.size() < DEPTH) || err_underflow !== m_err) begin
                n_errors++;
                $display("FAIL random_ctrl cycle %0d: got v=%b cnt=%0d rdy=%b err=%b expected v=%b cnt=%0d err=%b",
                         c, valid_out, exp_count, exp_ready, err_underflow, m_vout, q_re.size(), m_err);
            end
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (longint'($signed(dout_real[i])) != m_re[i] || longint'($signed(dout_imag[i])) != m_im[i]
                    || longint'($signed(dout_real2[i])) != m_re2[i]
                    || longint'($signed(dout_imag2[i])) != m_im2[i]) begin
                    n_errors++;
                    $display("FAIL random_lane cycle %0d lane %0d: got %0d/%0d %0d/%0d expected %0d/%0d %0d/%0d",
                             c, i, $signed(dout_real[i]), $signed(dout_imag[i]), $signed(dout_real2[i]),
                             $signed(dout_imag2[i]), m_re[i], m_im[i], m_re2[i], m_im2[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 10, 10, 0);
        drive(1, 12, 8, 0);
        randomize_stim();
        drive(0, 0, 0, 1);
        randomize_stim();
        drive(0, 0, 0, 1);
        n_checks++;
        if (valid_out !== 1'b1) begin
            n_errors++; $display("FAIL mid_before: got valid=%b expected 1", valid_out);
        end
        #2 rstn = 1'b1;
        #1;
        n_checks++;
        if (valid_out !== 1'b0 || err_underflow !== 1'b0 || exp_count !== 3'd0
            || exp_ready !== 1'b1 || dout_real !== '0 || dout_imag !== '0) begin
            n_errors++;
            $display("FAIL mid_reset: got v=%b err=%b cnt=%0d rdy=%b expected 0/0/0/1 with zero lanes",
                     valid_out, err_underflow, exp_count, exp_ready);
        end
        @(posedge clk);
        #1 rstn = 1'b0;
        model_reset();
        drive(0, 0, 0, 0);
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_errors++; $display("FAIL mid_discard: got valid=%b expected 0", valid_out);
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_left_shift();
        test_right_shift();
        test_fifo_full();
        test_underflow();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cbfp_denorm.md
Name: cbfp_denorm

Overview:
- Inverse end of the CBFP normalizer.
- The normalizer emits 16-lane blocks of reduced-width samples. For each block it also emits a per-block shift exponent for the real part and one for the imaginary part.
- This block queues those exponents in a small FIFO. When the matching normalized block arrives later in the pipeline (FFT output stage), it pops them and restores the original scale.
- Output is full-width, saturating, with a fixed 2-cycle pipeline.

Parameters:
- IN_WIDTH, 13: width of normalized input samples (signed).
- OUT_WIDTH, 23: width of denormalized output samples (signed).
- EXP_WIDTH, 5: width of each exponent (0..31).
- BIAS, 10: exponent that means unity gain. Net left shift = BIAS - exp.
- FIFO_DEPTH, 4: exponent FIFO entries (power of two, ≥2).

Ports:
- clk, input, 1: clock, all state on rising edge.
- rstn, input, 1: reset, asynchronous, active-high (asserted = 1).
- exp_valid, input, 1: exponent pair offered.
- exp_re, input, EXP_WIDTH: real exponent of one block.
- exp_im, input, EXP_WIDTH: imag exponent of one block.
- exp_ready, output, 1: FIFO not full. A push occurs when exp_valid && exp_ready.
- din_valid, input, 1: normalized block present this cycle.
- din_real, input, 16 x IN_WIDTH signed: normalized real lanes [15:0].
- din_imag, input, 16 x IN_WIDTH signed: normalized imag lanes [15:0].
- valid_out, output, 1: output block valid.
- dout_real, output, 16 x OUT_WIDTH signed: denormalized real lanes.
- dout_imag, output, 16 x OUT_WIDTH signed: denormalized imag lanes.
- exp_count, output, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- err_underflow, output, 1: sticky. Set when a block arrives with the FIFO empty.

Behaviour:
- Reset (rstn=1, async): FIFO pointers and count cleared. exp_ready=1, valid_out=0, all dout lanes=0, err_underflow=0, pipeline valids=0. Any block in flight is discarded.
- FIFO: pop occurs when din_valid=1 and count>0. exp_ready = (count < FIFO_DEPTH) and is evaluated on registered count; a simultaneous pop does not raise it. Push and pop in the same cycle leave count unchanged. No bypass: a push in cycle N is poppable from cycle N+1. Pointers wrap modulo FIFO_DEPTH.
- Underflow: din_valid=1 with count=0 still processes the block using exp_re=exp_im=BIAS (unity), sets err_underflow, and leaves count at 0. err_underflow clears only on reset.
- Stage 1 (cycle N+1): register din lanes and the popped exponents. Compute signed shift s = BIAS - exp (EXP_WIDTH+1 bits plus sign), separately for re and im.
- Stage 2 (cycle N+2): per lane, sign-extend to OUT_WIDTH+EXP_WIDTH bits.
  - s ≥ 0: shift left by s, then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - s < 0: arithmetic shift right by -s (floor toward -inf). A right shift of ≥ IN_WIDTH yields 0 or -1 by sign.
  - Register the result into dout lanes.
- Latency: din_valid at edge N → valid_out=1 with data at edge N+2. Back-to-back blocks give back-to-back outputs; throughput is one block per clock.
- valid_out=0 cycles: dout holds its last value.
- Re and im use independent exponents. All 16 lanes of a part share that part's exponent.

Test Plan:
- Reset, then push (exp_re=10, exp_im=10) and one block with real[0]=100, imag[0]=-7 → 2 cycles later valid_out=1, dout_real[0]=100, dout_imag[0]=-7, exp_count back to 0.
- Push (0,3). Block with real[i]=4095, imag[i]=100 → dout_real[i]=4193280, dout_imag[i]=12800. Repeat with real=-4096 → -4194304.
- Push (15,15). Block real[0]=-100, imag[0]=100 → dout_real[0]=-4, dout_imag[0]=3.
- OUT_WIDTH=20 build: push (0,0), real[0]=4095, imag[0]=-4096 → 524287 and -524288 (saturated).
- Push 4 pairs with no blocks → exp_count=4, exp_ready=0, a 5th exp_valid is ignored. Then 4 consecutive blocks → outputs use the exponents in push order, valid_out high for 4 consecutive cycles.
- With the FIFO empty, send a block real[0]=55 → dout_real[0]=55 and err_underflow=1, which stays set. Assert rstn mid-pipeline → valid_out=0 immediately, err_underflow=0, exp_count=0.
